// File: rtl/ewma_pkt_sequencer_if.sv
// ----------------------------------------------------------------------------
// ewma_pkt_sequencer_if
// Groups every packet, engine and decision-stage signal of the EWMA packet
// sequencer into one bundle.
//   master : the sequencer side (drives ready, engine enable/samples, results)
//   slave  : the environment side (packet source, EWMA engines, decision stage)
// Signals:
//   pkt_valid/pkt_rssi/pkt_snr  packet samples in (one-cycle pulse, no stall)
//   pkt_ready                   buffer has room
//   ewma_en/smp_rssi/smp_snr    engine enable pulse and held samples
//   rssi_done/rssi_ewma         RSSI engine completion and result
//   snr_done/snr_ewma           SNR engine completion and result
//   dec_valid/dec_rssi/dec_snr  result strobe and held result pair
//   dec_warm                    result qualified by warm-up count
//   drop_cnt/timeout_err/busy   status
// ----------------------------------------------------------------------------
interface ewma_pkt_sequencer_if #(
    parameter int DW = 32
);
    logic          pkt_valid;
    logic [DW-1:0] pkt_rssi;
    logic [DW-1:0] pkt_snr;
    logic          pkt_ready;
    logic          ewma_en;
    logic [DW-1:0] smp_rssi;
    logic [DW-1:0] smp_snr;
    logic          rssi_done;
    logic          snr_done;
    logic [DW-1:0] rssi_ewma;
    logic [DW-1:0] snr_ewma;
    logic          dec_valid;
    logic [DW-1:0] dec_rssi;
    logic [DW-1:0] dec_snr;
    logic          dec_warm;
    logic [15:0]   drop_cnt;
    logic          timeout_err;
    logic          busy;

    modport master (
        input  pkt_valid, pkt_rssi, pkt_snr,
        input  rssi_done, snr_done, rssi_ewma, snr_ewma,
        output pkt_ready, ewma_en, smp_rssi, smp_snr,
        output dec_valid, dec_rssi, dec_snr, dec_warm,
        output drop_cnt, timeout_err, busy
    );

    modport slave (
        output pkt_valid, pkt_rssi, pkt_snr,
        output rssi_done, snr_done, rssi_ewma, snr_ewma,
        input  pkt_ready, ewma_en, smp_rssi, smp_snr,
        input  dec_valid, dec_rssi, dec_snr, dec_warm,
        input  drop_cnt, timeout_err, busy
    );
endinterface

// File: rtl/ewma_pkt_sequencer.sv
// ----------------------------------------------------------------------------
// ewma_pkt_sequencer
// Sequences the RSSI and SNR EWMA engines for each received LoRa packet:
// buffers one packet, launches both engines with a single-cycle enable,
// collects both results (simultaneous or staggered), and hands the pair to
// the decision stage. Packets arriving while the buffer is full are counted
// as drops; engines that never finish raise a sticky timeout error.
// Ports:
//   clk_h  clock, rising edge
//   rst_h  asynchronous active-low reset (engines share it)
//   bus    ewma_pkt_sequencer_if.master, see the interface for signal roles
// Parameters:
//   DW       sample/result width (sign-magnitude, passed through untouched)
//   TIMEOUT  WAIT cycles allowed for both done flags (>= 2)
//   WARMUP   completed updates before dec_warm asserts (1..255)
// ----------------------------------------------------------------------------
module ewma_pkt_sequencer #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 16,
    parameter int WARMUP  = 4
) (
    input  logic                    clk_h,
    input  logic                    rst_h,
    ewma_pkt_sequencer_if.master    bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_REPORT = 2'd3;

    localparam int            TW   = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    logic [1:0]    r_state;
    logic          r_buf_full;
    logic [DW-1:0] r_buf_rssi;
    logic [DW-1:0] r_buf_snr;
    logic [15:0]   r_drop_cnt;
    logic          r_ewma_en;
    logic [DW-1:0] r_smp_rssi;
    logic [DW-1:0] r_smp_snr;
    logic          r_rssi_f;
    logic          r_snr_f;
    logic [DW-1:0] r_cap_rssi;
    logic [DW-1:0] r_cap_snr;
    logic [TW-1:0] r_timer;
    logic [7:0]    r_upd_cnt;
    logic          r_dec_valid;
    logic [DW-1:0] r_dec_rssi;
    logic [DW-1:0] r_dec_snr;
    logic          r_dec_warm;
    logic          r_timeout_err;

    logic w_accept;
    logic w_launch;
    logic w_rssi_ok;
    logic w_snr_ok;
    logic w_warm_next;

    assign w_accept  = bus.pkt_valid && !r_buf_full;
    assign w_launch  = (r_state == S_IDLE) && r_buf_full;
    // A done arriving this cycle counts as well as one latched earlier.
    assign w_rssi_ok = r_rssi_f || bus.rssi_done;
    assign w_snr_ok  = r_snr_f  || bus.snr_done;
    assign w_warm_next = (({1'b0, r_upd_cnt} + 9'd1) >= 9'(WARMUP));

    // One-entry input buffer and drop counter. Capture and drain never
    // coincide: capture needs an empty buffer, drain needs a full one.
    always_ff @(posedge clk_h or negedge rst_h) begin
        if (!rst_h) begin
            r_buf_full <= 1'b0;
            r_buf_rssi <= '0;
            r_buf_snr  <= '0;
            r_drop_cnt <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register sees the pre-edge values of its neighbours.
            if (w_accept) begin
                r_buf_full <= 1'b1;
                r_buf_rssi <= bus.pkt_rssi;
                r_buf_snr  <= bus.pkt_snr;
            end else if (w_launch) begin
                r_buf_full <= 1'b0;
            end
            if (bus.pkt_valid && r_buf_full && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    // Main sequencer. Results are gathered in shadow registers and copied to
    // dec_* only when the pair is complete, so an aborted WAIT leaves the
    // previously reported pair intact.
    always_ff @(posedge clk_h or negedge rst_h) begin
        if (!rst_h) begin
            r_state       <= S_IDLE;
            r_ewma_en     <= 1'b0;
            r_smp_rssi    <= '0;
            r_smp_snr     <= '0;
            r_rssi_f      <= 1'b0;
            r_snr_f       <= 1'b0;
            r_cap_rssi    <= '0;
            r_cap_snr     <= '0;
            r_timer       <= '0;
            r_upd_cnt     <= '0;
            r_dec_valid   <= 1'b0;
            r_dec_rssi    <= '0;
            r_dec_snr     <= '0;
            r_dec_warm    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            // NOTE: strobes default low here so they last exactly one cycle
            // unless a branch below raises them.
            r_ewma_en   <= 1'b0;
            r_dec_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (r_buf_full) begin
                        r_smp_rssi <= r_buf_rssi;
                        r_smp_snr  <= r_buf_snr;
                        r_rssi_f   <= 1'b0;
                        r_snr_f    <= 1'b0;
                        r_timer    <= '0;
                        r_ewma_en  <= 1'b1;
                        r_state    <= S_LAUNCH;
                    end
                end

                S_LAUNCH: begin
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    if (bus.rssi_done) begin
                        r_rssi_f   <= 1'b1;
                        r_cap_rssi <= bus.rssi_ewma;
                    end
                    if (bus.snr_done) begin
                        r_snr_f   <= 1'b1;
                        r_cap_snr <= bus.snr_ewma;
                    end
                    if (w_rssi_ok && w_snr_ok) begin
                        r_dec_rssi  <= bus.rssi_done ? bus.rssi_ewma : r_cap_rssi;
                        r_dec_snr   <= bus.snr_done  ? bus.snr_ewma  : r_cap_snr;
                        r_dec_valid <= 1'b1;
                        r_dec_warm  <= w_warm_next;
                        if (r_upd_cnt != 8'hFF) begin
                            r_upd_cnt <= r_upd_cnt + 8'd1;
                        end
                        r_state <= S_REPORT;
                    end else if (r_timer == TMAX) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end

                S_REPORT: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.pkt_ready   = !r_buf_full;
    assign bus.ewma_en     = r_ewma_en;
    assign bus.smp_rssi    = r_smp_rssi;
    assign bus.smp_snr     = r_smp_snr;
    assign bus.dec_valid   = r_dec_valid;
    assign bus.dec_rssi    = r_dec_rssi;
    assign bus.dec_snr     = r_dec_snr;
    assign bus.dec_warm    = r_dec_warm;
    assign bus.drop_cnt    = r_drop_cnt;
    assign bus.timeout_err = r_timeout_err;
    assign bus.busy        = (r_state != S_IDLE) || r_buf_full;

endmodule

// File: tb/tb_ewma_pkt_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ewma_pkt_sequencer
// Drives packets into ewma_pkt_sequencer, emulates both EWMA engines with a
// configurable done latency, and scores every dec_valid against a queue of
// expected result pairs pushed when each packet is sent.
// ----------------------------------------------------------------------------
module tb_ewma_pkt_sequencer;

    localparam int DW = 32;

    logic clk_h = 1'b0;
    logic rst_h = 1'b0;
    always #5 clk_h = ~clk_h;

    ewma_pkt_sequencer_if #(.DW(DW)) bus ();

    ewma_pkt_sequencer #(
        .DW      (DW),
        .TIMEOUT (16),
        .WARMUP  (4)
    ) dut (
        .clk_h (clk_h),
        .rst_h (rst_h),
        .bus   (bus)
    );

    typedef struct {
        logic [DW-1:0] rssi;
        logic [DW-1:0] snr;
        logic          warm;
    } exp_t;

    typedef struct {
        logic [DW-1:0] rssi;
        logic [DW-1:0] snr;
        int            rlat;
        int            slat;
        logic          warm;
        int            lat;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[6];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int dec_cnt  = 0;
    int en_cnt   = 0;
    int dec_cyc  = 0;
    int acc_cyc  = 0;

    bit eng_on = 1'b1;
    int rl     = 1;
    int sl     = 1;

    // Engine transfer functions used both by the engine model and for the
    // expected values.
    function automatic logic [DW-1:0] eng_r(input logic [DW-1:0] x);
        return x + 32'h0000_0100;
    endfunction

    function automatic logic [DW-1:0] eng_s(input logic [DW-1:0] x);
        return x ^ 32'h0F0F_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    always @(posedge clk_h) cyc <= cyc + 1;

    // Monitor / scoreboard.
    always @(negedge clk_h) begin
        if (rst_h) begin
            if (bus.ewma_en) en_cnt++;
            if (bus.dec_valid) begin
                dec_cnt++;
                dec_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_dec_valid: got dec_rssi 0x%08h with no result expected",
                             bus.dec_rssi);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("dec_rssi", bus.dec_rssi, mon_e.rssi);
                    check("dec_snr",  bus.dec_snr,  mon_e.snr);
                    check("dec_warm", 32'(bus.dec_warm), 32'(mon_e.warm));
                end
            end
        end
    end

    // EWMA engine model: on ewma_en, raise each done after its latency with
    // the result; results carry junk whenever done is low.
    initial begin : engine
        logic [DW-1:0] sr;
        logic [DW-1:0] ss;
        int            mx;
        forever begin
            @(negedge clk_h);
            if (rst_h && eng_on && bus.ewma_en) begin
                sr = bus.smp_rssi;
                ss = bus.smp_snr;
                mx = (rl > sl) ? rl : sl;
                for (int n = 1; n <= mx; n++) begin
                    @(negedge clk_h);
                    bus.rssi_done = (n == rl);
                    bus.rssi_ewma = (n == rl) ? eng_r(sr) : (eng_r(sr) ^ 32'hDEAD_BEEF);
                    bus.snr_done  = (n == sl);
                    bus.snr_ewma  = (n == sl) ? eng_s(ss) : (eng_s(ss) ^ 32'hBEEF_DEAD);
                end
                @(negedge clk_h);
                bus.rssi_done = 1'b0;
                bus.snr_done  = 1'b0;
            end
        end
    end

    task automatic send_pkt(input logic [DW-1:0] r, input logic [DW-1:0] s);
        @(negedge clk_h);
        bus.pkt_valid = 1'b1;
        bus.pkt_rssi  = r;
        bus.pkt_snr   = s;
        acc_cyc       = cyc;
        @(negedge clk_h);
        bus.pkt_valid = 1'b0;
    endtask

    task automatic wait_dec(input int target, input int budget, input string name);
        int k = 0;
        while (dec_cnt < target && k < budget) begin
            @(posedge clk_h);
            k++;
        end
        if (dec_cnt < target) begin
            n_checks++;
            $display("FAIL %s: timed out, dec_valid count %0d required %0d", name, dec_cnt, target);
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        do begin
            @(negedge clk_h);
            k++;
        end while (bus.busy && k < budget);
        if (bus.busy) begin
            n_checks++;
            $display("FAIL %s: timed out, busy still 1 required 0", name);
        end
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    initial begin : main
        int d0;
        int e0;

        bus.pkt_valid = 1'b0;
        bus.pkt_rssi  = '0;
        bus.pkt_snr   = '0;
        bus.rssi_done = 1'b0;
        bus.snr_done  = 1'b0;
        bus.rssi_ewma = '0;
        bus.snr_ewma  = '0;

        //            rssi           snr           rlat slat warm lat
        vecs[0] = '{32'h0000_0040, 32'h8000_0008, 1, 1, 1'b0, 4};
        vecs[1] = '{32'h0000_0123, 32'h8000_0456, 1, 3, 1'b0, 6};
        vecs[2] = '{32'h8000_0077, 32'h0000_0099, 3, 1, 1'b0, 6};
        vecs[3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 2, 2, 1'b1, 5};
        vecs[4] = '{32'h0000_0000, 32'h8000_0000, 1, 1, 1'b1, 4};
        vecs[5] = '{32'h1234_5678, 32'h8765_4321, 4, 2, 1'b1, 7};

        // Reset state.
        repeat (3) @(negedge clk_h);
        check("rst_ewma_en",     32'(bus.ewma_en),     32'd0);
        check("rst_dec_valid",   32'(bus.dec_valid),   32'd0);
        check("rst_dec_warm",    32'(bus.dec_warm),    32'd0);
        check("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
        check("rst_drop_cnt",    32'(bus.drop_cnt),    32'd0);
        check("rst_busy",        32'(bus.busy),        32'd0);
        check("rst_pkt_ready",   32'(bus.pkt_ready),   32'd1);
        check("rst_dec_rssi",    bus.dec_rssi,         32'd0);
        rst_h = 1'b1;
        repeat (2) @(negedge clk_h);

        // Table: single packets with simultaneous and staggered dones; the
        // six completions also walk dec_warm through the warm-up threshold.
        for (int i = 0; i < 6; i++) begin
            rl = vecs[i].rlat;
            sl = vecs[i].slat;
            d0 = dec_cnt;
            e0 = en_cnt;
            exp_q.push_back('{rssi: eng_r(vecs[i].rssi), snr: eng_s(vecs[i].snr), warm: vecs[i].warm});
            send_pkt(vecs[i].rssi, vecs[i].snr);
            wait_dec(d0 + 1, 40, $sformatf("vec%0d_dec", i));
            check($sformatf("vec%0d_latency", i), 32'(dec_cyc - acc_cyc), 32'(vecs[i].lat));
            wait_idle(20, $sformatf("vec%0d_idle", i));
            check($sformatf("vec%0d_en_pulses", i), 32'(en_cnt - e0), 32'd1);
        end

        // Engines never respond: abort after 16 WAIT cycles.
        eng_on = 1'b0;
        d0 = dec_cnt;
        send_pkt(32'h0000_0011, 32'h0000_0022);
        repeat (17) @(negedge clk_h);
        check("to_err_before",  32'(bus.timeout_err), 32'd0);
        check("to_busy_before", 32'(bus.busy),        32'd1);
        @(negedge clk_h);
        check("to_err_after",   32'(bus.timeout_err), 32'd1);
        check("to_busy_after",  32'(bus.busy),        32'd0);
        check("to_no_dec",      32'(dec_cnt),         32'(d0));
        check("to_dec_rssi_kept", bus.dec_rssi, eng_r(vecs[5].rssi));
        check("to_dec_snr_kept",  bus.dec_snr,  eng_s(vecs[5].snr));

        // Next packet after the timeout processes normally.
        eng_on = 1'b1;
        rl = 1;
        sl = 1;
        exp_q.push_back('{rssi: eng_r(32'h0000_0033), snr: eng_s(32'h8000_0044), warm: 1'b1});
        send_pkt(32'h0000_0033, 32'h8000_0044);
        wait_dec(d0 + 1, 40, "to_retry_dec");
        check("to_retry_latency", 32'(dec_cyc - acc_cyc), 32'd4);
        wait_idle(20, "to_retry_idle");
        check("to_err_sticky", 32'(bus.timeout_err), 32'd1);

        // Arrivals at cycles 0,3,4 with engine latency 2: run, buffer, drop.
        rl = 2;
        sl = 2;
        d0 = dec_cnt;
        exp_q.push_back('{rssi: eng_r(32'h0000_0050), snr: eng_s(32'h8000_0010), warm: 1'b1});
        exp_q.push_back('{rssi: eng_r(32'h0000_0060), snr: eng_s(32'h8000_0020), warm: 1'b1});
        @(negedge clk_h);
        bus.pkt_valid = 1'b1; bus.pkt_rssi = 32'h0000_0050; bus.pkt_snr = 32'h8000_0010;
        @(negedge clk_h);
        bus.pkt_valid = 1'b0;
        @(negedge clk_h);
        @(negedge clk_h);
        check("burst_ready_c3", 32'(bus.pkt_ready), 32'd1);
        bus.pkt_valid = 1'b1; bus.pkt_rssi = 32'h0000_0060; bus.pkt_snr = 32'h8000_0020;
        @(negedge clk_h);
        check("burst_ready_c4", 32'(bus.pkt_ready), 32'd0);
        bus.pkt_valid = 1'b1; bus.pkt_rssi = 32'h0000_0070; bus.pkt_snr = 32'h8000_0030;
        @(negedge clk_h);
        bus.pkt_valid = 1'b0;
        check("burst_ready_c5", 32'(bus.pkt_ready), 32'd0);
        @(negedge clk_h);
        check("burst_ready_c6", 32'(bus.pkt_ready), 32'd0);
        @(negedge clk_h);
        check("burst_ready_c7", 32'(bus.pkt_ready), 32'd1);
        wait_dec(d0 + 2, 60, "burst_dec");
        wait_idle(20, "burst_idle");
        repeat (4) @(negedge clk_h);
        check("burst_drop_cnt", 32'(bus.drop_cnt), 32'd1);
        check("burst_dec_count", 32'(dec_cnt - d0), 32'd2);

        // Asynchronous reset in the middle of WAIT.
        eng_on = 1'b0;
        send_pkt(32'h0000_0099, 32'h0000_00AA);
        repeat (3) @(negedge clk_h);
        check("rw_busy_in_wait", 32'(bus.busy), 32'd1);
        #2;
        rst_h = 1'b0;
        #1;
        check("rw_timeout_err", 32'(bus.timeout_err), 32'd0);
        check("rw_drop_cnt",    32'(bus.drop_cnt),    32'd0);
        check("rw_busy",        32'(bus.busy),        32'd0);
        check("rw_pkt_ready",   32'(bus.pkt_ready),   32'd1);
        check("rw_dec_warm",    32'(bus.dec_warm),    32'd0);
        check("rw_dec_rssi",    bus.dec_rssi,         32'd0);
        check("rw_smp_rssi",    bus.smp_rssi,         32'd0);
        @(negedge clk_h);
        rst_h  = 1'b1;
        eng_on = 1'b1;
        d0 = dec_cnt;
        repeat (20) @(negedge clk_h);
        check("rw_no_dec_after", 32'(dec_cnt), 32'(d0));
        check("rw_idle_after",   32'(bus.busy), 32'd0);

        // Update count restarted by reset: first result is cold again.
        rl = 1;
        sl = 2;
        exp_q.push_back('{rssi: eng_r(32'h8000_0005), snr: eng_s(32'h0000_0006), warm: 1'b0});
        send_pkt(32'h8000_0005, 32'h0000_0006);
        wait_dec(d0 + 1, 40, "post_rst_dec");
        check("post_rst_latency", 32'(dec_cyc - acc_cyc), 32'd5);
        wait_idle(20, "post_rst_idle");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
